i2c_write_sched: RTL

I2C_WRITE_SCHED -- requirements
Module: i2c_write_sched

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_scl_gen.sv | 34 +++
 rtl/i2c_write_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write scheduler.
// RETRY_WAIT is reachable only when I2C_SCHED_RETRY_EN is defined.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        ACK,
        STOP,
        DONE,
        RETRY_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SLV,
        REG,
        DATA
    } byte_idx_t;

    localparam logic WRITE_BIT = 1'b0;

    // Wide enough for the largest legal CLK_DIV (4095).
    localparam int DIV_W = 12;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-period timebase: divides clk by CLK_DIV and counts quarters 0..3.
// The counter holds at zero while not running and restarts on clear.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    output logic [1:0] quarter,
    output logic       q_start,
    output logic       q_end
);

    logic [DIV_W-1:0] div_cnt;

    assign q_start = (div_cnt == '0);
    assign q_end   = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !run || clear) begin
            div_cnt <= '0;
            quarter <= '0;
        end else if (q_end) begin
            div_cnt <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2c_write_sched.sv
// Two-requester round-robin I2C single-byte register writer (addr, reg, data).
// Define I2C_SCHED_RETRY_EN to retry a NACKed transaction once after a short gap.
module i2c_write_sched
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [6:0] slv_addr0,
    input  logic [6:0] slv_addr1,
    input  logic [7:0] reg_addr0,
    input  logic [7:0] reg_addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] gnt,
    output logic       done,
    output logic       nack,
    output logic       busy,
    output logic       scl,
    inout  wire        sda
);

    state_t     state, next_state;
    byte_idx_t  byte_idx, next_idx;
    logic [7:0] next_byte;
    logic       rr_prio1;
    logic [6:0] slv_q;
    logic [7:0] reg_q, wdata_q, shreg;
    logic [2:0] bit_cnt;
    logic       nack_flag, sda_low, run, clear;
    logic [1:0] quarter;
    logic       q_start, q_end;
`ifdef I2C_SCHED_RETRY_EN
    logic       retried;
`endif

    // Done cycle blocks a grant so a waiting request is taken on the clk after done.
    always_comb begin
        gnt = 2'b00;
        if (!reset && state == IDLE && !done) begin
            if (req[0] && (!req[1] || !rr_prio1)) gnt = 2'b01;
            else if (req[1])                      gnt = 2'b10;
        end
    end

    assign busy  = (state != IDLE) || done || (gnt != 2'b00);
    assign run   = !(state == IDLE || state == DONE);
    assign clear = (next_state != state);
    assign sda   = sda_low ? 1'b0 : 1'bz;

    i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .clear   (clear),
        .quarter (quarter),
        .q_start (q_start),
        .q_end   (q_end)
    );

    always_comb begin
        next_idx  = byte_idx;
        next_byte = wdata_q;
        case (byte_idx)
            SLV: begin next_idx = REG;  next_byte = reg_q;   end
            REG: begin next_idx = DATA; next_byte = wdata_q; end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        scl        = 1'b1;
        sda_low    = 1'b0;
        case (state)
            IDLE: if (gnt != 2'b00) next_state = START;
            START: begin
                sda_low = 1'b1;
                scl     = (quarter != 2'd2);
                if (q_end && quarter == 2'd2) next_state = BYTE;
            end
            BYTE: begin
                sda_low = !shreg[7];
                scl     = (quarter == 2'd1) || (quarter == 2'd2);
                if (q_end && quarter == 2'd3 && bit_cnt == 3'd7) next_state = ACK;
            end
            ACK: begin
                scl = (quarter == 2'd1) || (quarter == 2'd2);
                if (q_end && quarter == 2'd3)
                    next_state = (nack_flag || byte_idx == DATA) ? STOP : BYTE;
            end
            STOP: begin
                sda_low = (quarter != 2'd2);
                scl     = (quarter != 2'd0);
                if (q_end && quarter == 2'd2) begin
                    next_state = DONE;
`ifdef I2C_SCHED_RETRY_EN
                    if (nack_flag && !retried) next_state = RETRY_WAIT;
`endif
                end
            end
`ifdef I2C_SCHED_RETRY_EN
            RETRY_WAIT: if (q_end && quarter == 2'd3) next_state = START;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_prio1  <= 1'b0;
            slv_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_idx  <= SLV;
            nack_flag <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
`ifdef I2C_SCHED_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            done  <= (state == DONE);
            nack  <= (state == DONE) && nack_flag;
            if (gnt != 2'b00) begin
                slv_q    <= gnt[1] ? slv_addr1 : slv_addr0;
                reg_q    <= gnt[1] ? reg_addr1 : reg_addr0;
                wdata_q  <= gnt[1] ? wdata1    : wdata0;
                rr_prio1 <= gnt[0];
`ifdef I2C_SCHED_RETRY_EN
                retried  <= 1'b0;
`endif
            end
            // Each attempt (first or retry) starts with a clean NACK flag.
            if (next_state == START && state != START) nack_flag <= 1'b0;
            case (state)
                START: if (next_state == BYTE) begin
                    shreg    <= {slv_q, WRITE_BIT};
                    byte_idx <= SLV;
                    bit_cnt  <= '0;
                end
                BYTE: if (q_end && quarter == 2'd3) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ACK: begin
                    if (q_start && quarter == 2'd2) nack_flag <= sda;
                    if (next_state == BYTE) begin
                        byte_idx <= next_idx;
                        shreg    <= next_byte;
                    end
                end
`ifdef I2C_SCHED_RETRY_EN
                STOP: if (next_state == RETRY_WAIT) retried <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
